// File: rtl/debounce_sync_pkg.sv
// Shared types and limits for the debounce_sync input-conditioning block.
// Imported by the top-level FSM and by the bench.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } db_state_t;

    localparam int DB_MIN_CYCLES = 2;

endpackage

// File: rtl/debounce_sync_if.sv
// Pin-side bundle of debounce_sync: raw level in, clean level, complement and strobes out.
// The master drives the raw level; the slave (debounce_sync) drives everything else.
interface debounce_sync_if;

    logic a;
    logic y;
    logic y_n;
    logic rise;
    logic fall;

    modport master (output a, input y, input y_n, input rise, input fall);
    modport slave  (input a, output y, output y_n, output rise, output fall);

endinterface

// File: rtl/debounce_sync_sync_chain.sv
// Purpose: multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: q follows d after STAGES rising edges.
// Backpressure: none; free-running level path.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Purpose: synchronise and debounce a slow async level into y/y_n plus rise/fall strobes.
// Latency: y and strobe update SYNC_STAGES-1+DEBOUNCE_CYCLES edges after a stable level is first sampled.
// Backpressure: none; strobes are single-cycle and never stall.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic           clk,
    input logic           rst_n,
    debounce_sync_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < DB_MIN_CYCLES) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES must be at least %0d", DB_MIN_CYCLES);
    end

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("debounce_sync: SYNC_STAGES must be at least 2");
    end

    logic             s;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             y_q;
    logic             y_nxt;
    logic             rise_q;
    logic             rise_nxt;
    logic             fall_q;
    logic             fall_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.a),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOW;
            cnt    <= '0;
            y_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            y_q    <= y_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    // The sample that enters a CHK state counts as the first of the window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LOW: begin
                if (s) begin
                    state_nxt = CHK_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    y_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_nxt = CHK_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    y_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
                y_nxt     = 1'b0;
            end
        endcase
    end

    assign bus.y    = y_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

    not u_y_n (bus.y_n, y_q);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a SYNC_STAGES=3 sweep over DEBOUNCE_CYCLES.
// All instances share one raw input and are tracked against a window-based reference model.
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int NM = 4;
    localparam int MS [NM] = '{2, 3, 3, 3};
    localparam int MD [NM] = '{4, 2, 4, 7};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a     = 1'b0;
    logic chk_on = 1'b0;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    debounce_sync_if if0 ();
    debounce_sync_if if1 ();
    debounce_sync_if if2 ();
    debounce_sync_if if3 ();

    assign if0.a = a;
    assign if1.a = a;
    assign if2.a = a;
    assign if3.a = a;

    debounce_sync u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) u_sw2 (.clk(clk), .rst_n(rst_n), .bus(if1));
    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(4)) u_sw4 (.clk(clk), .rst_n(rst_n), .bus(if2));
    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(7)) u_sw7 (.clk(clk), .rst_n(rst_n), .bus(if3));

    // {y, y_n, rise, fall} per instance
    logic [3:0] dut_o [NM];
    assign dut_o[0] = {if0.y, if0.y_n, if0.rise, if0.fall};
    assign dut_o[1] = {if1.y, if1.y_n, if1.rise, if1.fall};
    assign dut_o[2] = {if2.y, if2.y_n, if2.rise, if2.fall};
    assign dut_o[3] = {if3.y, if3.y_n, if3.rise, if3.fall};

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: after each sampling edge, the level the FSM has seen at edge k is a(k-S).
    // y flips when the last D such samples all differ from y.
    function automatic logic [31:0] full(input int d);
        return (32'd1 << d) - 32'd1;
    endfunction

    function automatic logic [31:0] win(input logic [31:0] h, input int s, input int d);
        return (h >> s) & full(d);
    endfunction

    logic [31:0] mh [NM];
    logic        my [NM];
    logic        mr [NM];
    logic        mf [NM];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NM; i++) begin
                mh[i] <= '0;
                my[i] <= 1'b0;
                mr[i] <= 1'b0;
                mf[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NM; i++) begin
                mh[i] <= {mh[i][30:0], a};
                mr[i] <= 1'b0;
                mf[i] <= 1'b0;
                if (!my[i] && win({mh[i][30:0], a}, MS[i], MD[i]) == full(MD[i])) begin
                    my[i] <= 1'b1;
                    mr[i] <= 1'b1;
                end else if (my[i] && win({mh[i][30:0], a}, MS[i], MD[i]) == 32'd0) begin
                    my[i] <= 1'b0;
                    mf[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NM; i++) begin
                chk($sformatf("model[%0d]", i), dut_o[i], {my[i], ~my[i], mr[i], mf[i]});
            end
        end
    end

    // Latency probe: edge index n=0 is the first edge after the call.
    int   lat      [NM];
    logic strb_at  [NM];
    logic strb_nxt [NM];

    task automatic measure(input logic target);
        for (int i = 0; i < NM; i++) begin
            lat[i]      = -1;
            strb_at[i]  = 1'b0;
            strb_nxt[i] = 1'b1;
        end
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NM; i++) begin
                if (lat[i] >= 0 && lat[i] == n - 1)
                    strb_nxt[i] = target ? dut_o[i][1] : dut_o[i][0];
                if (lat[i] < 0 && dut_o[i][3] == target) begin
                    lat[i]     = n;
                    strb_at[i] = target ? dut_o[i][1] : dut_o[i][0];
                end
            end
        end
        for (int i = 0; i < NM; i++) begin
            chk_int($sformatf("latency[%0d] to %0b", i, target), lat[i], MS[i] - 1 + MD[i]);
            chk($sformatf("strobe_at[%0d]", i), {3'b0, strb_at[i]}, 4'd1);
            chk($sformatf("strobe_next[%0d]", i), {3'b0, strb_nxt[i]}, 4'd0);
        end
    endtask

    typedef struct {
        logic  a;
        int    hold;
        logic  exp_y;
        int    exp_rise;
        int    exp_fall;
        string name;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin
        tbl[0] = '{1'b1, 20, 1'b1, 1, 0, "step_up"};
        tbl[1] = '{1'b0, 20, 1'b0, 0, 1, "step_down"};
        tbl[2] = '{1'b1,  3, 1'b0, 0, 0, "glitch_pulse"};
        tbl[3] = '{1'b0, 20, 1'b0, 0, 0, "glitch_quiet"};
        tbl[4] = '{1'b1,  2, 1'b0, 0, 0, "bounce_1a"};
        tbl[5] = '{1'b0,  2, 1'b0, 0, 0, "bounce_0a"};
        tbl[6] = '{1'b1,  2, 1'b0, 0, 0, "bounce_1b"};
        tbl[7] = '{1'b0,  2, 1'b0, 0, 0, "bounce_0b"};
        tbl[8] = '{1'b1, 20, 1'b1, 1, 0, "bounce_hold"};
        tbl[9] = '{1'b0, 20, 1'b0, 0, 1, "back_low"};

        // Reset with a=1 held, released mid-cycle.
        a     = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_on = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_hold", dut_o[0], 4'b0100);
        end
        rst_n = 1'b1;
        measure(1'b1);

        @(negedge clk);
        a = 1'b0;
        measure(1'b0);

        // Table-driven level sequences on the default instance.
        @(negedge clk);
        for (int v = 0; v < NV; v++) begin
            int nr;
            int nf;
            nr = 0;
            nf = 0;
            a = tbl[v].a;
            for (int c = 0; c < tbl[v].hold; c++) begin
                @(negedge clk);
                nr += int'(if0.rise);
                nf += int'(if0.fall);
            end
            chk({tbl[v].name, ".y"}, {3'b0, if0.y}, {3'b0, tbl[v].exp_y});
            chk_int({tbl[v].name, ".rise"}, nr, tbl[v].exp_rise);
            chk_int({tbl[v].name, ".fall"}, nf, tbl[v].exp_fall);
        end

        // Random level sequences; the model checker follows every cycle.
        for (int r = 0; r < 80; r++) begin
            a = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end

        // Reset asserted mid-qualification.
        a = 1'b0;
        repeat (20) @(negedge clk);
        a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midq_cnt", {1'b0, u_dut.cnt}, 4'd2);
        chk("midq_state", {2'b0, u_dut.state}, {2'b0, CHK_HIGH});
        rst_n = 1'b0;
        #1;
        chk("midq_state_rst", {2'b0, u_dut.state}, {2'b0, LOW});
        chk("midq_out_rst", dut_o[0], 4'b0100);
        begin
            int nr;
            nr = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                nr += int'(if0.rise);
                if (c == 3) a = 1'b0;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                nr += int'(if0.rise);
            end
            chk_int("midq_no_rise", nr, 0);
        end
        chk("midq_final", dut_o[0], 4'b0100);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
